// File: rtl/csa_pkg.sv
// Shared constants and elaboration-time helpers for the carry-save accumulator.
package csa_pkg;

  localparam int CSA_WIDTH_DEFAULT = 32;

  // Number of vectors left after one level of 3:2 rows over n vectors.
  function automatic int csa_next_count(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Tree depth: levels of 3:2 rows needed to bring n vectors down to two.
  function automatic int csa_levels(input int n);
    int cnt;
    int lvl;
    cnt = n;
    lvl = 0;
    while (cnt > 2) begin
      cnt = csa_next_count(cnt);
      lvl++;
    end
    return lvl;
  endfunction

  // Vectors present at the input of tree level lvl when starting from n.
  function automatic int csa_count_at(input int n, input int lvl);
    int cnt;
    cnt = n;
    for (int i = 0; i < lvl; i++) begin
      cnt = csa_next_count(cnt);
    end
    return cnt;
  endfunction

  // Tree inputs per beat. The accumulator pair always occupies two slots
  // (zeroed when not accumulating) so the tree shape never depends on acc.
  function automatic int csa_ops_total(input int num_ops, input bit acc);
    return num_ops + (acc ? 2 : 2);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: three vectors in, redundant sum/carry pair out.
module csa_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] VS,
  output logic [WIDTH-1:0] VC
);

  logic [WIDTH-1:0] halfSum;
  logic [WIDTH-1:0] majority;

  // Bitwise full adders; the carry is shifted up one place and its MSB dropped,
  // which keeps everything mod 2^WIDTH.
  always_comb begin
    halfSum  = X ^ Y;
    majority = (X & Y) | (halfSum & Z);
    VS       = halfSum ^ Z;
    VC       = {majority[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/csa_accum_pipe.sv
// Pipelined multi-operand carry-save accumulator: compressor tree in the accept
// cycle, a redundant stage-1 register, and a carry-propagating output register.
module csa_accum_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH   = CSA_WIDTH_DEFAULT,
  parameter int NUM_OPS = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [NUM_OPS*WIDTH-1:0] OPS,
  input  logic                     ACC,
  input  logic                     LAST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         SUM
);

  localparam int N      = csa_ops_total(NUM_OPS, 1'b1);
  localparam int LEVELS = csa_levels(N);

  logic [WIDTH-1:0] accS_q, accS_d, accC_q, accC_d;
  logic [WIDTH-1:0] s1S_q, s1S_d, s1C_q, s1C_d;
  logic             s1V_q, s1V_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             outValid_q, outValid_d;

  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] vec [0:LEVELS][0:N-1];

  // Level 0 of the tree: the operands followed by the (optionally zeroed) accumulator pair.
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ops
    assign vec[0][k] = OPS[k*WIDTH +: WIDTH];
  end
  assign vec[0][NUM_OPS]   = ACC ? accS_q : '0;
  assign vec[0][NUM_OPS+1] = ACC ? accC_q : '0;

  // Each level groups vectors in threes; leftovers drop straight to the next level.
  for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
    localparam int CNT    = csa_count_at(N, lvl);
    localparam int GROUPS = CNT / 3;
    localparam int REM    = CNT % 3;
    localparam int NEXT   = 2 * GROUPS + REM;

    for (genvar g = 0; g < GROUPS; g++) begin : g_row
      csa_row #(.WIDTH(WIDTH)) uRow (
        .X (vec[lvl][3*g]),
        .Y (vec[lvl][3*g+1]),
        .Z (vec[lvl][3*g+2]),
        .VS(vec[lvl+1][2*g]),
        .VC(vec[lvl+1][2*g+1])
      );
    end

    for (genvar r = 0; r < REM; r++) begin : g_pass
      assign vec[lvl+1][2*GROUPS+r] = vec[lvl][3*GROUPS+r];
    end

    for (genvar u = NEXT; u < N; u++) begin : g_unused
      assign vec[lvl+1][u] = '0;
    end
  end

  // Stage 1 can hand off whenever the output is empty or being drained this edge.
  assign advance  = s1V_q && (!outValid_q || OUT_READY);
  assign IN_READY = !s1V_q || !outValid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  assign OUT_VALID = outValid_q;
  assign SUM       = sum_q;

  // Next-state for accumulator, stage 1 and output register; a fresh load always beats a drain.
  always_comb begin
    accS_d     = accS_q;
    accC_d     = accC_q;
    s1S_d      = s1S_q;
    s1C_d      = s1C_q;
    s1V_d      = s1V_q;
    sum_d      = sum_q;
    outValid_d = outValid_q;

    if (advance) begin
      sum_d      = s1S_q + s1C_q;
      outValid_d = 1'b1;
      s1V_d      = 1'b0;
    end else if (OUT_READY) begin
      outValid_d = 1'b0;
    end

    if (accept) begin
      if (LAST) begin
        s1S_d  = vec[LEVELS][0];
        s1C_d  = vec[LEVELS][1];
        s1V_d  = 1'b1;
        accS_d = '0;
        accC_d = '0;
      end else begin
        accS_d = vec[LEVELS][0];
        accC_d = vec[LEVELS][1];
      end
    end
  end

  // All state registers; reset throws away any partial or in-flight sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      accS_q     <= '0;
      accC_q     <= '0;
      s1S_q      <= '0;
      s1C_q      <= '0;
      s1V_q      <= 1'b0;
      sum_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      accS_q     <= accS_d;
      accC_q     <= accC_d;
      s1S_q      <= s1S_d;
      s1C_q      <= s1C_d;
      s1V_q      <= s1V_d;
      sum_q      <= sum_d;
      outValid_q <= outValid_d;
    end
  end

endmodule
